// File: rtl/rtc_calendar_pkg.sv
// Shared types and constants for the real-time calendar counter.
package rtc_pkg;

  // Width of every time/date field
  localparam int RTC_W = 7;

  // Upper range limits for the time/date fields
  localparam logic [RTC_W-1:0] SEC_MAX   = 7'd59;
  localparam logic [RTC_W-1:0] MIN_MAX   = 7'd59;
  localparam logic [RTC_W-1:0] HOUR_MAX  = 7'd23;
  localparam logic [RTC_W-1:0] MONTH_MAX = 7'd12;
  localparam logic [RTC_W-1:0] YEAR_MAX  = 7'd99;

  // Lower limits of the one-based fields
  localparam logic [RTC_W-1:0] DAY_MIN   = 7'd1;
  localparam logic [RTC_W-1:0] MONTH_MIN = 7'd1;

  // Reset date: 00:00:00 1/1/2000
  localparam logic [RTC_W-1:0] RST_SEC   = 7'd0;
  localparam logic [RTC_W-1:0] RST_MIN   = 7'd0;
  localparam logic [RTC_W-1:0] RST_HOUR  = 7'd0;
  localparam logic [RTC_W-1:0] RST_DAY   = 7'd1;
  localparam logic [RTC_W-1:0] RST_MONTH = 7'd1;
  localparam logic [RTC_W-1:0] RST_YEAR  = 7'd0;

  // Complete calendar state
  typedef struct packed {
    logic [RTC_W-1:0] sec;
    logic [RTC_W-1:0] min;
    logic [RTC_W-1:0] hour;
    logic [RTC_W-1:0] day;
    logic [RTC_W-1:0] month;
    logic [RTC_W-1:0] year;
  } rtc_time_t;

  localparam rtc_time_t RST_TIME = '{
    sec:   RST_SEC,
    min:   RST_MIN,
    hour:  RST_HOUR,
    day:   RST_DAY,
    month: RST_MONTH,
    year:  RST_YEAR
  };

endpackage

// File: rtl/rtc_calendar_if.sv
// Load/control inputs and calendar outputs of the RTC, bundled as one port.
interface rtc_calendar_if;
  import rtc_pkg::*;

  logic             run;
  logic             set_valid;
  logic [RTC_W-1:0] set_sec;
  logic [RTC_W-1:0] set_min;
  logic [RTC_W-1:0] set_hour;
  logic [RTC_W-1:0] set_day;
  logic [RTC_W-1:0] set_month;
  logic [RTC_W-1:0] set_year;
  logic             set_err;
  logic             tick_1hz;
  logic [RTC_W-1:0] Sec;
  logic [RTC_W-1:0] Min;
  logic [RTC_W-1:0] Hour;
  logic [RTC_W-1:0] Day;
  logic [RTC_W-1:0] Month;
  logic [RTC_W-1:0] Year;

  // Controller side: drives run/load, observes the calendar
  modport master (
    output run, set_valid, set_sec, set_min, set_hour, set_day, set_month, set_year,
    input  set_err, tick_1hz, Sec, Min, Hour, Day, Month, Year
  );

  // Calendar side
  modport slave (
    input  run, set_valid, set_sec, set_min, set_hour, set_day, set_month, set_year,
    output set_err, tick_1hz, Sec, Min, Hour, Day, Month, Year
  );

endinterface

// File: rtl/rtc_days_in_month.sv
// Number of days in a given month of a given year 2000..2099.
module rtc_days_in_month
  import rtc_pkg::*;
(
  input  logic [RTC_W-1:0] month,
  input  logic [RTC_W-1:0] year,
  output logic [4:0]       days
);

  logic leap;

  // Every multiple of four in 2000..2099 is a leap year, including 2000 itself
  assign leap = ((year % 7'd4) == 7'd0);

  // Month length lookup; out-of-range months fall into the 31-day default and
  // are rejected separately by the load range checks
  always_comb begin
    days = 5'd31;
    case (month)
      7'd2:                      days = leap ? 5'd29 : 5'd28;
      7'd4, 7'd6, 7'd9, 7'd11:   days = 5'd30;
      default:                   days = 5'd31;
    endcase
  end

endmodule

// File: rtl/rtc_calendar.sv
// Real-time calendar: 1 Hz prescaler, sec..year carry chain, validated load.
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  rtc_calendar_if.slave bus
);

  localparam int            PW       = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] pre_q, pre_d;
  rtc_time_t     time_q, time_d;
  logic          tick_q, tick_d;
  logic          err_q, err_d;

  rtc_time_t     set_time;
  rtc_time_t     adv_time;
  logic [4:0]    cur_dim;
  logic [4:0]    set_dim;
  logic          set_ok;
  logic          wrap;

  assign set_time = '{
    sec:   bus.set_sec,
    min:   bus.set_min,
    hour:  bus.set_hour,
    day:   bus.set_day,
    month: bus.set_month,
    year:  bus.set_year
  };

  // Length of the current month drives the day carry
  rtc_days_in_month u_cur_dim (
    .month (time_q.month),
    .year  (time_q.year),
    .days  (cur_dim)
  );

  // Length of the requested month bounds the requested day
  rtc_days_in_month u_set_dim (
    .month (bus.set_month),
    .year  (bus.set_year),
    .days  (set_dim)
  );

  // A load is accepted only if the whole date/time it describes is real
  always_comb begin
    set_ok = (bus.set_sec   <= SEC_MAX)   &&
             (bus.set_min   <= MIN_MAX)   &&
             (bus.set_hour  <= HOUR_MAX)  &&
             (bus.set_month >= MONTH_MIN) &&
             (bus.set_month <= MONTH_MAX) &&
             (bus.set_year  <= YEAR_MAX)  &&
             (bus.set_day   >= DAY_MIN)   &&
             (bus.set_day   <= RTC_W'(set_dim));
  end

  // Full one-second carry chain from seconds to year, resolved in one cycle
  always_comb begin
    adv_time = time_q;
    if (time_q.sec != SEC_MAX) begin
      adv_time.sec = time_q.sec + 1'b1;
    end else begin
      adv_time.sec = '0;
      if (time_q.min != MIN_MAX) begin
        adv_time.min = time_q.min + 1'b1;
      end else begin
        adv_time.min = '0;
        if (time_q.hour != HOUR_MAX) begin
          adv_time.hour = time_q.hour + 1'b1;
        end else begin
          adv_time.hour = '0;
          if (time_q.day != RTC_W'(cur_dim)) begin
            adv_time.day = time_q.day + 1'b1;
          end else begin
            adv_time.day = DAY_MIN;
            if (time_q.month != MONTH_MAX) begin
              adv_time.month = time_q.month + 1'b1;
            end else begin
              adv_time.month = MONTH_MIN;
              adv_time.year  = (time_q.year == YEAR_MAX) ? '0 : time_q.year + 1'b1;
            end
          end
        end
      end
    end
  end

  assign wrap = bus.run && (pre_q == PRE_LAST);

  // Next state: prescaler/advance first, then an accepted load overrides both
  always_comb begin
    pre_d  = pre_q;
    time_d = time_q;
    tick_d = 1'b0;
    err_d  = 1'b0;
    if (wrap) begin
      pre_d  = '0;
      time_d = adv_time;
      tick_d = 1'b1;
    end else if (bus.run) begin
      pre_d = pre_q + 1'b1;
    end
    if (bus.set_valid) begin
      if (set_ok) begin
        time_d = set_time;
        pre_d  = '0;
        tick_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous return to the reset date
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      time_q <= RST_TIME;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      time_q <= time_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign bus.Sec      = time_q.sec;
  assign bus.Min      = time_q.min;
  assign bus.Hour     = time_q.hour;
  assign bus.Day      = time_q.day;
  assign bus.Month    = time_q.month;
  assign bus.Year     = time_q.year;
  assign bus.tick_1hz = tick_q;
  assign bus.set_err  = err_q;

endmodule
